fanout_front_end: RTL and testbench

FANOUT_FRONT_END -- requirements
Module: fanout_front_end

---
 rtl/fanout_front_end.sv | 182 ++++++++++++++++++
 tb/tb_fanout_front_end.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fanout_front_end.sv
// rtl/fanout_front_end.sv - message front end: header capture, backend handshake, data write gating
package fanout_pkg;

  // Forward token: valid plus a token code; payload travels beside it to the buffers.
  typedef struct packed {
    logic       v;
    logic [2:0] tok;
  } FTk_t;

  // Back-prop token: n is the nack; s is a sideband bit this block never drives.
  typedef struct packed {
    logic n;
    logic s;
  } BTk_t;

  localparam logic [2:0] TK_DATA    = 3'd0;
  localparam logic [2:0] TK_ACQ_MSG = 3'd1;
  localparam logic [2:0] TK_ACQ_FLG = 3'd2;
  localparam logic [2:0] TK_RLS_MSG = 3'd3;
  localparam logic [2:0] TK_RLS_FLG = 3'd4;

  typedef struct packed {
    logic acq_message;
    logic acq_flagmsg;
    logic rls_message;
    logic rls_flagmsg;
  } tok_dec_t;

  // Unassigned codes decode as plain data.
  function automatic tok_dec_t TokenDec(input logic [2:0] tok);
    tok_dec_t d;
    d.acq_message = (tok == TK_ACQ_MSG);
    d.acq_flagmsg = (tok == TK_ACQ_FLG);
    d.rls_message = (tok == TK_RLS_MSG);
    d.rls_flagmsg = (tok == TK_RLS_FLG);
    return d;
  endfunction

endpackage

module fanout_front_end #(
  parameter int NUM_ID = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  fanout_pkg::FTk_t I_FTk,
  output fanout_pkg::BTk_t O_BTk,
  input  fanout_pkg::BTk_t I_BTk,
  output logic             O_Req,
  input  logic             I_Ack,
  output logic             O_We_BUFF_ID,
  output logic             O_We_BUFF,
  input  logic             I_Full_Buff,
  output logic             O_Unit_Length,
  output logic             O_is_Busy
);

  // Counter holds up to NUM_ID-1; NUM_ID must be at least 2.
  localparam int CW = $clog2(NUM_ID);
  localparam logic [CW-1:0] LAST_ID = CW'(NUM_ID - 1);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_CAPT_ID = 2'd1,
    ST_REQ     = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                r_full;
  logic                r_first;
  logic                w_first_nxt;
  logic                r_unit_len;
  logic                w_unit_len_nxt;
  logic                w_nack;
  logic                w_acc;
  logic                w_acquire;
  logic                w_release;
  logic                w_we_id;
  logic                w_we_data;
  logic                w_unused_btk_s;
  fanout_pkg::tok_dec_t w_dec;

  assign w_unused_btk_s = I_BTk.s;

  assign w_dec     = fanout_pkg::TokenDec(I_FTk.tok);
  assign w_acquire = w_dec.acq_message | w_dec.acq_flagmsg;
  assign w_release = w_dec.rls_message | w_dec.rls_flagmsg;

  // Nack while the buffer was full last cycle, downstream pushes back, or the
  // backend has not yet granted the pending request.
  assign w_nack = r_full | I_BTk.n | ((r_state == ST_REQ) & ~I_Ack);
  assign w_acc  = I_FTk.v & ~w_nack;

  assign O_BTk.n       = w_nack;
  assign O_BTk.s       = 1'b0;
  assign O_Req         = (r_state == ST_REQ);
  assign O_We_BUFF_ID  = w_we_id;
  assign O_We_BUFF     = w_we_data;
  assign O_Unit_Length = r_unit_len;
  assign O_is_Busy     = (r_state != ST_INIT);

  // State, ID counter, first-word and unit-length flags, registered buffer-full.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_first    <= 1'b0;
      r_unit_len <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_full     <= I_Full_Buff;
      r_first    <= w_first_nxt;
      r_unit_len <= w_unit_len_nxt;
    end
  end

  // Next-state and write-enable decode; only accepted tokens move anything.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_first_nxt    = r_first;
    w_unit_len_nxt = r_unit_len;
    w_we_id        = 1'b0;
    w_we_data      = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (w_acc && w_acquire) begin
          w_we_id        = 1'b1;
          w_cnt_nxt      = CW'(1);
          w_unit_len_nxt = 1'b0;
          w_state_nxt    = ST_CAPT_ID;
        end
      end
      ST_CAPT_ID: begin
        if (w_acc) begin
          if (w_release) begin
            // A release inside the header abandons the message without a write.
            w_cnt_nxt   = '0;
            w_state_nxt = ST_INIT;
          end else begin
            w_we_id = 1'b1;
            if (r_cnt == LAST_ID) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_REQ;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end
        end
      end
      ST_REQ: begin
        if (I_Ack) begin
          w_first_nxt = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_acc) begin
          w_we_data   = 1'b1;
          w_first_nxt = 1'b0;
          if (w_release) begin
            if (r_first) begin
              w_unit_len_nxt = 1'b1;
            end
            w_state_nxt = ST_INIT;
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_fanout_front_end.sv
// tb/tb_fanout_front_end.sv - scoreboard bench for fanout_front_end
module tb_fanout_front_end;
  import fanout_pkg::*;

  logic clock = 1'b0;
  logic reset;
  FTk_t I_FTk;
  BTk_t O_BTk;
  BTk_t I_BTk;
  logic O_Req;
  logic I_Ack;
  logic O_We_BUFF_ID;
  logic O_We_BUFF;
  logic I_Full_Buff;
  logic O_Unit_Length;
  logic O_is_Busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_we_id = 0;
  int n_we_data = 0;
  logic [3:0] sb_q[$];

  fanout_front_end #(.NUM_ID(3)) dut (
    .clock(clock),
    .reset(reset),
    .I_FTk(I_FTk),
    .O_BTk(O_BTk),
    .I_BTk(I_BTk),
    .O_Req(O_Req),
    .I_Ack(I_Ack),
    .O_We_BUFF_ID(O_We_BUFF_ID),
    .O_We_BUFF(O_We_BUFF),
    .I_Full_Buff(I_Full_Buff),
    .O_Unit_Length(O_Unit_Length),
    .O_is_Busy(O_is_Busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void expect_wr(input bit is_id, input logic [2:0] tok);
    sb_q.push_back({is_id, tok});
  endfunction

  // Every write pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (O_We_BUFF_ID && O_We_BUFF) begin
      check_eq("we_exclusive", 1, 0);
    end else if (O_We_BUFF_ID || O_We_BUFF) begin
      if (O_We_BUFF_ID) n_we_id++;
      else n_we_data++;
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_write", sb_q.size(), 1);
      end else begin
        logic [3:0] exp_v;
        exp_v = sb_q.pop_front();
        check_eq("sb_write", int'({O_We_BUFF_ID, I_FTk.tok}), int'(exp_v));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [2:0] tok, input bit is_id, input bit wr);
    bit done;
    done = 1'b0;
    I_FTk.v   = 1'b1;
    I_FTk.tok = tok;
    if (wr) expect_wr(is_id, tok);
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clock);
      if (!O_BTk.n) done = 1'b1;
      tick();
    end
    I_FTk.v   = 1'b0;
    I_FTk.tok = TK_DATA;
    check_eq("send_accepted", int'(done), 1);
  endtask

  task automatic header_rest();
    send(TK_DATA, 1'b1, 1'b1);
    send(TK_DATA, 1'b1, 1'b1);
    @(negedge clock);
    check_eq("req_cycle1", O_Req, 1);
    tick();
    I_Ack = 1'b1;
    @(negedge clock);
    check_eq("req_cycle2", O_Req, 1);
    tick();
    I_Ack = 1'b0;
    @(negedge clock);
    check_eq("req_dropped", O_Req, 0);
    check_eq("busy_in_run", O_is_Busy, 1);
    tick();
  endtask

  task automatic header(input logic [2:0] acq_tok);
    send(acq_tok, 1'b1, 1'b1);
    header_rest();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base_id;
    int base_data;
    reset       = 1'b1;
    I_FTk.v     = 1'b0;
    I_FTk.tok   = TK_DATA;
    I_BTk.n     = 1'b0;
    I_BTk.s     = 1'b0;
    I_Ack       = 1'b0;
    I_Full_Buff = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    check_eq("rst_req", O_Req, 0);
    check_eq("rst_we_id", O_We_BUFF_ID, 0);
    check_eq("rst_we", O_We_BUFF, 0);
    check_eq("rst_btk", int'(O_BTk), 0);
    check_eq("rst_busy", O_is_Busy, 0);
    check_eq("rst_unit", O_Unit_Length, 0);
    tick();
    reset = 1'b0;

    // Non-acquire token in INIT is consumed with no write.
    send(TK_DATA, 1'b0, 1'b0);
    @(negedge clock);
    check_eq("init_ignore_busy", O_is_Busy, 0);
    tick();

    // Header of three ID words, ack two cycles after request.
    base_id = n_we_id;
    header(TK_ACQ_MSG);
    check_eq("hdr_id_pulses", n_we_id - base_id, 3);

    // Four data words and release, with one downstream nack on the way.
    base_data = n_we_data;
    I_BTk.n   = 1'b1;
    I_FTk.v   = 1'b1;
    I_FTk.tok = TK_DATA;
    expect_wr(1'b0, TK_DATA);
    @(negedge clock);
    check_eq("btk_nack", O_BTk.n, 1);
    check_eq("btk_no_write", O_We_BUFF, 0);
    tick();
    I_BTk.n = 1'b0;
    @(negedge clock);
    check_eq("btk_release_write", O_We_BUFF, 1);
    tick();
    I_FTk.v = 1'b0;
    for (int i = 0; i < 3; i++) send(TK_DATA, 1'b0, 1'b1);
    send(TK_RLS_MSG, 1'b0, 1'b1);
    @(negedge clock);
    check_eq("msg_data_pulses", n_we_data - base_data, 5);
    check_eq("msg_idle", O_is_Busy, 0);
    check_eq("msg_unit_len", O_Unit_Length, 0);
    tick();

    // Unit-length message: release is the first data word.
    base_data = n_we_data;
    header(TK_ACQ_FLG);
    send(TK_RLS_FLG, 1'b0, 1'b1);
    @(negedge clock);
    check_eq("unit_pulses", n_we_data - base_data, 1);
    check_eq("unit_set", O_Unit_Length, 1);
    check_eq("unit_idle", O_is_Busy, 0);
    repeat (3) tick();
    @(negedge clock);
    check_eq("unit_held", O_Unit_Length, 1);
    tick();
    send(TK_ACQ_MSG, 1'b1, 1'b1);
    @(negedge clock);
    check_eq("unit_cleared", O_Unit_Length, 0);
    tick();
    header_rest();

    // Buffer full for three cycles in RUN: nack lags by one cycle both ways.
    send(TK_DATA, 1'b0, 1'b1);
    base_data   = n_we_data;
    I_Full_Buff = 1'b1;
    @(negedge clock);
    check_eq("full_lag_rise", O_BTk.n, 0);
    tick();
    I_FTk.v   = 1'b1;
    I_FTk.tok = TK_DATA;
    expect_wr(1'b0, TK_DATA);
    @(negedge clock);
    check_eq("full_nack1", O_BTk.n, 1);
    tick();
    @(negedge clock);
    check_eq("full_nack2", O_BTk.n, 1);
    tick();
    I_Full_Buff = 1'b0;
    @(negedge clock);
    check_eq("full_nack_fall", O_BTk.n, 1);
    check_eq("full_no_writes", n_we_data - base_data, 0);
    tick();
    @(negedge clock);
    check_eq("full_released", O_BTk.n, 0);
    check_eq("full_word_written", O_We_BUFF, 1);
    tick();
    I_FTk.v = 1'b0;
    send(TK_RLS_MSG, 1'b0, 1'b1);
    @(negedge clock);
    check_eq("full_not_unit", O_Unit_Length, 0);
    tick();

    // Release arriving as ID1 aborts the header without a request.
    send(TK_ACQ_MSG, 1'b1, 1'b1);
    send(TK_RLS_MSG, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("abort_no_req", O_Req, 0);
      check_eq("abort_idle", O_is_Busy, 0);
      tick();
    end
    // Counter must be back at zero: a fresh header needs exactly three words.
    base_id = n_we_id;
    header(TK_ACQ_MSG);
    check_eq("abort_then_hdr", n_we_id - base_id, 3);
    send(TK_RLS_MSG, 1'b0, 1'b1);

    // Reset while in REQ.
    send(TK_ACQ_MSG, 1'b1, 1'b1);
    send(TK_DATA, 1'b1, 1'b1);
    send(TK_DATA, 1'b1, 1'b1);
    @(negedge clock);
    check_eq("pre_rst_req", O_Req, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_req_drop", O_Req, 0);
    check_eq("rst_req_idle", O_is_Busy, 0);
    check_eq("rst_req_btk", int'(O_BTk), 0);
    tick();

    repeat (2) tick();
    check_eq("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
